// File: rtl/qspi_xip_fetch.sv
// XIP instruction fetch: serves CPU instruction words from QSPI NOR flash (Quad Output Fast Read).
// Latency: hit 0 cycles; cold miss 89 cycles; sequential miss in an open burst 9; other miss 91.
// Backpressure: WAIT_INSTR stalls the CPU until the one-word buffer holds the requested word.
//
// Ports:
//   clk, rstn            system clock, synchronous active-low reset
//   fetch_req            instruction fetch outside the ASRAM window
//   cpu_iaddr            16-bit word address, held stable while WAIT_INSTR=1
//   instr, WAIT_INSTR    buffered instruction word and stall
//   QSPI_CLK, QSPI_CSN   flash clock (clk/2, mode 0) and chip select
//   qspi_dio_o/_oe/_i    split quad data pads; the top level builds the tristate
module qspi_xip_fetch #(
    parameter int          BUS_AWIDTH   = 24,
    parameter logic [7:0]  READ_CMD     = 8'h6B,
    parameter int          DUMMY_SCK    = 8,
    parameter int          CSN_HIGH_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fetch_req,
    input  logic [BUS_AWIDTH-1:0] cpu_iaddr,
    output logic [15:0]           instr,
    output logic                  WAIT_INSTR,
    output logic                  QSPI_CLK,
    output logic                  QSPI_CSN,
    output logic [3:0]            qspi_dio_o,
    output logic [3:0]            qspi_dio_oe,
    input  logic [3:0]            qspi_dio_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CSHIGH = 3'd1;
    localparam logic [2:0] S_CMD    = 3'd2;
    localparam logic [2:0] S_ADDR   = 3'd3;
    localparam logic [2:0] S_DUMMY  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;

    localparam logic [7:0] CMD_SCK   = 8'd8;
    localparam logic [7:0] ADDR_SCK  = 8'd24;
    localparam logic [7:0] DATA_SCK  = 8'd4;
    localparam logic [7:0] DUMMY_CNT = 8'(DUMMY_SCK);
    // CSHIGH counts down to zero, so it lasts CSH_INIT+1 cycles.
    localparam logic [7:0] CSH_INIT  = (CSN_HIGH_CYC > 1) ? 8'(CSN_HIGH_CYC - 1) : 8'd0;

    logic [2:0]  state_q, state_d;
    logic        phase_q, phase_d;      // 0: SCK low (phase A), 1: SCK high (phase B)
    logic [7:0]  cnt_q,   cnt_d;        // SCK periods left in state, or CSN-high cycles left
    logic [31:0] sh_q,    sh_d;         // {opcode, byte address}, MSB goes out on DIO0
    logic [11:0] rx_q,    rx_d;         // first three nibbles of the word being read
    logic [22:0] addr_q,  addr_d;       // word address of the burst in flight
    logic [22:0] tag_q,   tag_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;

    logic [22:0] req_addr;
    logic [22:0] tag_next;
    logic        hit;
    logic        miss;
    logic        seq;
    logic        sck_end;
    logic [15:0] rx_full;
    logic        unused_addr_hi;

    assign req_addr       = cpu_iaddr[22:0];
    assign unused_addr_hi = ^cpu_iaddr[BUS_AWIDTH-1:23];
    assign tag_next       = tag_q + 23'd1;   // wraps mod 2^23, so 0x7FFFFF -> 0 is sequential
    assign hit            = valid_q && (tag_q == req_addr);
    assign miss           = fetch_req && !hit;
    assign seq            = (req_addr == tag_next);
    assign sck_end        = phase_q;         // the edge ending phase B closes an SCK period
    // Nibbles arrive byte0-high, byte0-low, byte1-high, byte1-low; even byte is the low half.
    assign rx_full        = {rx_q, qspi_dio_i};

    always_comb begin
        state_d = state_q;
        phase_d = 1'b0;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        instr_d = instr_q;

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    addr_d  = req_addr;
                    sh_d    = {READ_CMD, req_addr, 1'b0};
                    cnt_d   = CMD_SCK;
                    state_d = S_CMD;
                end
            end

            S_CSHIGH: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = CMD_SCK;
                    state_d = S_CMD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_CMD, S_ADDR: begin
                phase_d = !phase_q;
                if (sck_end) begin
                    sh_d = {sh_q[30:0], 1'b0};
                    if (cnt_q == 8'd1) begin
                        if (state_q == S_CMD) begin
                            cnt_d   = ADDR_SCK;
                            state_d = S_ADDR;
                        end else if (DUMMY_SCK == 0) begin
                            cnt_d   = DATA_SCK;
                            state_d = S_DATA;
                        end else begin
                            cnt_d   = DUMMY_CNT;
                            state_d = S_DUMMY;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_DUMMY: begin
                phase_d = !phase_q;
                if (sck_end) begin
                    if (cnt_q == 8'd1) begin
                        cnt_d   = DATA_SCK;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_DATA: begin
                phase_d = !phase_q;
                if (sck_end) begin
                    rx_d = rx_full[11:0];
                    if (cnt_q == 8'd1) begin
                        // Buffer is written only here, so a hit never sees instr move.
                        instr_d = {rx_full[7:0], rx_full[15:8]};
                        tag_d   = addr_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_HOLD: begin
                // SCK parked low with CSN asserted; the flash keeps its read pointer.
                if (miss) begin
                    addr_d = req_addr;
                    if (seq) begin
                        cnt_d   = DATA_SCK;
                        state_d = S_DATA;
                    end else begin
                        sh_d    = {READ_CMD, req_addr, 1'b0};
                        cnt_d   = CSH_INIT;
                        state_d = S_CSHIGH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= 8'd0;
            sh_q    <= 32'd0;
            rx_q    <= 12'd0;
            addr_q  <= 23'd0;
            tag_q   <= 23'd0;
            valid_q <= 1'b0;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
        end
    end

    // Pad outputs decode registered state only, so they change right after the clk edge.
    always_comb begin
        qspi_dio_o  = 4'b1100;
        qspi_dio_oe = 4'b1100;
        case (state_q)
            S_CMD, S_ADDR: begin
                // DIO2/DIO3 double as WP#/HOLD# and must stay high while driven.
                qspi_dio_o  = {2'b11, 1'b0, sh_q[31]};
                qspi_dio_oe = 4'b1101;
            end
            S_DUMMY, S_DATA, S_HOLD: begin
                qspi_dio_oe = 4'b0000;
            end
            default: begin
                qspi_dio_oe = 4'b1100;
            end
        endcase
    end

    assign QSPI_CSN   = (state_q == S_IDLE) || (state_q == S_CSHIGH);
    assign QSPI_CLK   = phase_q && ((state_q == S_CMD) || (state_q == S_ADDR) ||
                                    (state_q == S_DUMMY) || (state_q == S_DATA));
    assign instr      = instr_q;
    assign WAIT_INSTR = miss;

endmodule

// File: tb/tb_qspi_xip_fetch.sv
// Directed bench for qspi_xip_fetch with a behavioural quad-output flash model.
// Latency: measured in clk cycles from the cycle a request is first presented.
// Backpressure: the bench holds each request until WAIT_INSTR drops or a cycle budget expires.
module tb_qspi_xip_fetch;

    localparam int DUMMY   = 8;
    localparam int BUDGET  = 300;
    localparam int DATA_AT = 32 + DUMMY + 1;   // SCK rising edges seen when first data nibble is sampled

    logic        clk;
    logic        rstn;
    logic        fetch_req;
    logic [23:0] cpu_iaddr;
    logic [15:0] instr;
    logic        WAIT_INSTR;
    logic        QSPI_CLK;
    logic        QSPI_CSN;
    logic [3:0]  qspi_dio_o;
    logic [3:0]  qspi_dio_oe;
    logic [3:0]  qspi_dio_i;

    int n_checks = 0;
    int n_errors = 0;

    qspi_xip_fetch #(
        .BUS_AWIDTH   (24),
        .READ_CMD     (8'h6B),
        .DUMMY_SCK    (DUMMY),
        .CSN_HIGH_CYC (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fetch_req   (fetch_req),
        .cpu_iaddr   (cpu_iaddr),
        .instr       (instr),
        .WAIT_INSTR  (WAIT_INSTR),
        .QSPI_CLK    (QSPI_CLK),
        .QSPI_CSN    (QSPI_CSN),
        .qspi_dio_o  (qspi_dio_o),
        .qspi_dio_oe (qspi_dio_oe),
        .qspi_dio_i  (qspi_dio_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- flash model ----------------
    // Contents: byte = a[7:0] ^ a[15:8] ^ 0x5A, except bytes 0x20/0x21 = 0x34/0x12.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h000020) return 8'h34;
        if (a == 24'h000021) return 8'h12;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [3:0] flash_nib(input logic [23:0] base, input int idx);
        logic [7:0] b;
        b = flash_byte(base + 24'(idx / 2));
        return (idx[0] == 1'b0) ? b[7:4] : b[3:0];
    endfunction

    int          sck_edges = 0;
    int          sck_total = 0;
    logic [7:0]  cmd_cap   = 8'h00;
    logic [23:0] addr_cap  = 24'h000000;

    always @(posedge QSPI_CLK or posedge QSPI_CSN) begin
        if (QSPI_CSN) begin
            sck_edges <= 0;
        end else begin
            if (sck_edges < 8)
                cmd_cap <= {cmd_cap[6:0], qspi_dio_o[0]};
            else if (sck_edges < 32)
                addr_cap <= {addr_cap[22:0], qspi_dio_o[0]};
            sck_edges <= sck_edges + 1;
        end
    end

    always @(posedge QSPI_CLK) sck_total <= sck_total + 1;

    assign qspi_dio_i = (!QSPI_CSN && sck_edges >= DATA_AT) ?
                        flash_nib(addr_cap, sck_edges - DATA_AT) : 4'h0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a request and counts cycles until WAIT_INSTR drops (0 = hit in the same cycle).
    task automatic fetch(input logic [23:0] a, output int lat, output int csn_hi,
                         output logic csn1);
        @(negedge clk);
        cpu_iaddr = a;
        fetch_req = 1'b1;
        lat    = 0;
        csn_hi = 0;
        csn1   = 1'bx;
        #1;
        while (WAIT_INSTR && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (QSPI_CSN) csn_hi++;
            if (lat == 1) csn1 = QSPI_CSN;
        end
    endtask

    int   lat;
    int   csn_hi;
    logic csn1;
    int   sck_before;

    initial begin
        rstn      = 1'b0;
        fetch_req = 1'b0;
        cpu_iaddr = 24'h0;
        repeat (3) @(negedge clk);

        check("rst_csn",   32'(QSPI_CSN),    32'h1);
        check("rst_sck",   32'(QSPI_CLK),    32'h0);
        check("rst_instr", 32'(instr),       32'h0000);
        check("rst_oe",    32'(qspi_dio_oe), 32'hC);
        check("rst_wait",  32'(WAIT_INSTR),  32'h0);
        rstn = 1'b1;

        // Cold miss.
        fetch(24'h000010, lat, csn_hi, csn1);
        check("cold_lat",   32'(lat),      32'd89);
        check("cold_csn1",  32'(csn1),     32'h0);
        check("cold_cmd",   32'(cmd_cap),  32'h6B);
        check("cold_addr",  32'(addr_cap), 32'h000020);
        check("cold_instr", 32'(instr),    32'h1234);

        // Sequential miss in the open burst.
        fetch(24'h000011, lat, csn_hi, csn1);
        check("seq_lat",   32'(lat),    32'd9);
        check("seq_csnhi", 32'(csn_hi), 32'd0);
        check("seq_instr", 32'(instr),  32'h7978);

        // Non-sequential miss.
        fetch(24'h000200, lat, csn_hi, csn1);
        check("jmp_lat",   32'(lat),      32'd91);
        check("jmp_csnhi", 32'(csn_hi),   32'd2);
        check("jmp_cmd",   32'(cmd_cap),  32'h6B);
        check("jmp_addr",  32'(addr_cap), 32'h000400);
        check("jmp_instr", 32'(instr),    32'h5F5E);

        // Hit on the buffered word.
        sck_before = sck_total;
        fetch(24'h000200, lat, csn_hi, csn1);
        check("hit_lat", 32'(lat), 32'd0);
        repeat (5) @(negedge clk);
        check("hit_sck",   32'(sck_total - sck_before), 32'd0);
        check("hit_wait",  32'(WAIT_INSTR),             32'h0);
        check("hit_instr", 32'(instr),                  32'h5F5E);

        // Reset while the address phase of a new command is on the wire.
        @(negedge clk);
        cpu_iaddr = 24'h000300;
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_csn",   32'(QSPI_CSN),    32'h1);
        check("mid_rst_sck",   32'(QSPI_CLK),    32'h0);
        check("mid_rst_oe",    32'(qspi_dio_oe), 32'hC);
        check("mid_rst_do",    32'(qspi_dio_o),  32'hC);
        check("mid_rst_instr", 32'(instr),       32'h0000);
        check("mid_rst_wait",  32'(WAIT_INSTR),  32'h1);
        fetch_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Cold fetch of the last word, then wrap to word 0 as a sequential fetch.
        fetch(24'h7FFFFF, lat, csn_hi, csn1);
        check("top_lat",   32'(lat),      32'd89);
        check("top_addr",  32'(addr_cap), 32'hFFFFFE);
        check("top_instr", 32'(instr),    32'h5A5B);

        fetch(24'h000000, lat, csn_hi, csn1);
        check("wrap_lat",   32'(lat),    32'd9);
        check("wrap_csnhi", 32'(csn_hi), 32'd0);
        check("wrap_instr", 32'(instr),  32'h5B5A);

        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qspi_xip_fetch.md
# qspi_xip_fetch

Execute-in-place instruction fetch unit for the LS1u SoC. It serves CPU instruction fetches whose address falls outside the on-board ASRAM window by reading a serial NOR flash over QSPI (Quad Output Fast Read, 0x6B, mode 0, SCK = clk/2). It sits beside the ASRAM interface on the instruction port and presents the same `instr`/`WAIT_INSTR` handshake. A one-word buffer and an open-burst HOLD state make sequential fetches cost 4 SCK periods instead of a full command.

## Interface
- `BUS_AWIDTH`, 24: CPU instruction address width; `cpu_iaddr` is a 16-bit-word address.
- `READ_CMD`, 8'h6B: flash read opcode.
- `DUMMY_SCK`, 8: dummy SCK periods between address and data.
- `CSN_HIGH_CYC`, 2: minimum CSN-high clk cycles between bursts.
- `clk` in 1: system clock; the only clock.
- `rstn` in 1: reset, synchronous, active-low.
- `fetch_req` in 1: fetch request (top drives `!ram_isel`).
- `cpu_iaddr` in BUS_AWIDTH: instruction word address; held stable by the CPU while `WAIT_INSTR`=1.
- `instr` out 16: buffered instruction word.
- `WAIT_INSTR` out 1: stall; `fetch_req & !(buf_valid & buf_tag==cpu_iaddr[22:0])`.
- `QSPI_CLK` out 1, `QSPI_CSN` out 1.
- `qspi_dio_o` out 4, `qspi_dio_oe` out 4, `qspi_dio_i` in 4: split pad signals; top builds the tristate.

## Operation
- Flash byte address = {cpu_iaddr[22:0],1'b0}. Byte at even address -> `instr[7:0]`, odd -> `instr[15:8]`. Each byte arrives high nibble first, DIO3 = nibble MSB.
- Buffer: `instr`, 23-bit `buf_tag`, `buf_valid`. Hit when `fetch_req` and valid and tag matches: `WAIT_INSTR`=0 combinationally in that cycle.
- States: IDLE, CSHIGH, CMD (8 SCK), ADDR (24 SCK), DUMMY (DUMMY_SCK), DATA (4 SCK), HOLD.
- IDLE: miss -> latch address, CMD. CSN goes low on entry to CMD.
- CMD/ADDR: MSB first on DIO0; `qspi_dio_oe`=4'b1101, DIO2/DIO3 driven 1 (WP#/HOLD# high), DIO1 input.
- DUMMY/DATA: `qspi_dio_oe`=4'b0000.
- DATA end: write `instr`, tag, valid=1; -> HOLD (CSN stays low, SCK stopped low).
- HOLD: miss with `cpu_iaddr[22:0]` == tag+1 (mod 2^23) -> DATA directly (flash streams next word). Other miss -> CSN high, CSHIGH for CSN_HIGH_CYC cycles, then CMD. No request or hit -> stay.
- IDLE/CSHIGH/reset outputs: `qspi_dio_oe`=4'b1100, `qspi_dio_o`=4'b1100.
- `fetch_req` dropping or `cpu_iaddr` changing mid-burst: burst completes for latched address, buffer updated, then HOLD re-evaluates.
- Reset values: CSN=1, QSPI_CLK=0, `instr`=16'h0000, buf_valid=0, state IDLE. Reset mid-burst aborts immediately (CSN high next edge).

## Timing
- SCK period = 2 clk: phase A SCK=0, outputs updated at its start; phase B SCK=1, inputs sampled at the clk edge ending phase B.
- Cold miss accepted in IDLE at cycle T: CSN low from T+1; 8+24+DUMMY_SCK+4 = 44 SCK periods occupy T+1..T+88; `instr` valid and `WAIT_INSTR`=0 at T+89.
- Sequential miss in HOLD at cycle S: periods S+1..S+8; valid at S+9.
- Non-sequential miss in HOLD at S: CSN high S+1..S+2; CMD from S+3; valid at S+91.
- Hit: 0 wait cycles.
- Buffer updates only at DATA completion; `instr` never changes while a hit is being consumed.

## Test plan
- Reset, then `fetch_req`=1, iaddr=0x000010, flash bytes 0x20,0x21 = 0x34,0x12 -> CSN low next cycle, DIO0 shows 0x6B then 0x000020, `instr`=16'h1234, WAIT_INSTR falls exactly 89 cycles after request.
- Follow with iaddr 0x000011 -> no new command, 4 SCK periods, valid 9 cycles later, CSN never rises.
- Then iaddr 0x000200 -> CSN high exactly 2 cycles, full command with address 0x000400, 91-cycle latency.
- Re-request 0x000200 -> WAIT_INSTR=0 same cycle, no SCK activity.
- Deassert `rstn` during ADDR -> next edge CSN=1, SCK=0, oe=4'b1100, instr=0; next request performs full cold fetch.
- Sequential across wrap: tag 0x7FFFFF then iaddr 0x000000 (bits[22:0]) -> treated as sequential, continues burst.
